// File: rtl/ibex_mult_pext_seq_pkg.sv
// ibex_mult_pext_seq_pkg: shared types for the P/M-extension multiplier sequencer.
package ibex_mult_pext_seq_pkg;

    typedef enum logic [1:0] {
        M8x8   = 2'b00,
        M16x16 = 2'b01,
        M32x16 = 2'b10,
        M32x32 = 2'b11
    } mult_pext_mode_e;

    typedef enum logic [1:0] {
        PH_LO  = 2'b00,
        PH_HI  = 2'b01,
        PH_ACC = 2'b10
    } mult_phase_e;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'b00,
        SEQ_MUL_HI = 2'b01,
        SEQ_ACC    = 2'b10
    } seq_state_e;

    // With accumulate folded into the last multiply, the ACC step disappears.
    function automatic logic [1:0] eff_code(input logic fold, input logic [1:0] code);
        return fold ? {1'b0, code[0]} : code;
    endfunction

endpackage

// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq: phase sequencer for the shared multiplier datapath; latches the
// decode at op start and drives intermediate-write, accumulate and valid strobes.
module ibex_mult_pext_seq
    import ibex_mult_pext_seq_pkg::*;
#(
    parameter bit FoldAccum = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mult_en_i,
    input  logic       kill_i,
    input  logic [1:0] mult_mode_i,
    input  logic [1:0] cycle_count_i,
    input  logic [1:0] accum_sub_i,
    input  logic       dsum_i,
    input  logic       crossed_i,
    input  logic       sat_i,
    output logic [1:0] phase_o,
    output logic [1:0] mode_o,
    output logic [1:0] accum_sub_o,
    output logic       dsum_o,
    output logic       crossed_o,
    output logic       imd_we_o,
    output logic       acc_en_o,
    output logic       valid_o,
    output logic       sat_o,
    output logic       busy_o
);

    seq_state_e  state_q, state_d;
    mult_phase_e phase;
    logic [1:0]  mode_q, code_q, sub_q;
    logic        dsum_q, crossed_q, sat_q, sat_d;
    logic        idle, abort, start, valid, imd_we, acc_en;
    logic [1:0]  code_in_eff, code_q_eff;

    assign idle        = state_q == SEQ_IDLE;
    assign abort       = kill_i | rst_i;
    assign start       = idle & mult_en_i & ~abort;
    assign code_in_eff = eff_code(FoldAccum, cycle_count_i);
    assign code_q_eff  = eff_code(FoldAccum, code_q);

    always_comb begin
        state_d = state_q;
        phase   = PH_LO;
        valid   = 1'b0;
        imd_we  = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (mult_en_i) begin
                    if (code_in_eff == 2'b00) begin
                        valid  = 1'b1;
                        acc_en = FoldAccum & cycle_count_i[1];
                    end else begin
                        imd_we  = 1'b1;
                        state_d = (code_in_eff == 2'b10) ? SEQ_ACC : SEQ_MUL_HI;
                    end
                end
            end
            SEQ_MUL_HI: begin
                phase = PH_HI;
                if (code_q_eff == 2'b11) begin
                    imd_we  = 1'b1;
                    state_d = SEQ_ACC;
                end else begin
                    valid   = 1'b1;
                    acc_en  = FoldAccum & code_q[1];
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_ACC: begin
                phase   = PH_ACC;
                valid   = 1'b1;
                acc_en  = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
        // Flush or reset suppresses every strobe of the aborted cycle.
        if (abort) begin
            state_d = SEQ_IDLE;
            valid   = 1'b0;
            imd_we  = 1'b0;
            acc_en  = 1'b0;
        end
    end

    assign sat_d = (kill_i | valid) ? 1'b0 : (start | ~idle) ? (sat_q | sat_i) : sat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SEQ_IDLE;
            mode_q    <= 2'b00;
            code_q    <= 2'b00;
            sub_q     <= 2'b00;
            dsum_q    <= 1'b0;
            crossed_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= sat_d;
            if (start) begin
                mode_q    <= mult_mode_i;
                code_q    <= cycle_count_i;
                sub_q     <= accum_sub_i;
                dsum_q    <= dsum_i;
                crossed_q <= crossed_i;
            end
        end
    end

    assign phase_o     = phase;
    assign mode_o      = idle ? mult_mode_i : mode_q;
    assign accum_sub_o = idle ? accum_sub_i : sub_q;
    assign dsum_o      = idle ? dsum_i : dsum_q;
    assign crossed_o   = idle ? crossed_i : crossed_q;
    assign imd_we_o    = imd_we;
    assign acc_en_o    = acc_en;
    assign valid_o     = valid;
    assign sat_o       = valid & (sat_q | sat_i);
    assign busy_o      = ~idle;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// tb_ibex_mult_pext_seq: directed scoreboard bench for the sequencer, with and without
// accumulate folding, checking every output vector each cycle.
module tb_ibex_mult_pext_seq;

    logic       clk = 1'b0;
    logic       rst, en, kill, dsum, cr, sat;
    logic [1:0] mode, cc, sub;

    logic [1:0] ph_m, md_m, sb_m, ph_f, md_f, sb_f;
    logic       ds_m, cr_m, iw_m, ae_m, v_m, st_m, bz_m;
    logic       ds_f, cr_f, iw_f, ae_f, v_f, st_f, bz_f;
    logic [12:0] om, of;

    typedef struct {
        string       tag;
        logic        cm;
        logic [12:0] em;
        logic        cf;
        logic [12:0] ef;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ibex_mult_pext_seq #(.FoldAccum(1'b0)) dut_m (
        .clk_i(clk), .rst_i(rst), .mult_en_i(en), .kill_i(kill), .mult_mode_i(mode),
        .cycle_count_i(cc), .accum_sub_i(sub), .dsum_i(dsum), .crossed_i(cr), .sat_i(sat),
        .phase_o(ph_m), .mode_o(md_m), .accum_sub_o(sb_m), .dsum_o(ds_m), .crossed_o(cr_m),
        .imd_we_o(iw_m), .acc_en_o(ae_m), .valid_o(v_m), .sat_o(st_m), .busy_o(bz_m)
    );

    ibex_mult_pext_seq #(.FoldAccum(1'b1)) dut_f (
        .clk_i(clk), .rst_i(rst), .mult_en_i(en), .kill_i(kill), .mult_mode_i(mode),
        .cycle_count_i(cc), .accum_sub_i(sub), .dsum_i(dsum), .crossed_i(cr), .sat_i(sat),
        .phase_o(ph_f), .mode_o(md_f), .accum_sub_o(sb_f), .dsum_o(ds_f), .crossed_o(cr_f),
        .imd_we_o(iw_f), .acc_en_o(ae_f), .valid_o(v_f), .sat_o(st_f), .busy_o(bz_f)
    );

    assign om = {ph_m, md_m, sb_m, ds_m, cr_m, iw_m, ae_m, v_m, st_m, bz_m};
    assign of = {ph_f, md_f, sb_f, ds_f, cr_f, iw_f, ae_f, v_f, st_f, bz_f};

    // {phase, mode, sub, dsum, crossed, imd_we, acc_en, valid, sat, busy}
    function automatic logic [12:0] x(input logic [1:0] p, m, s, input logic d, c, w, a, v, t, b);
        return {p, m, s, d, c, w, a, v, t, b};
    endfunction

    task automatic step(input string tag, input logic r, e, k, input logic [1:0] md, cnt, sb,
                        input logic d, c, st, input logic cm, input logic [12:0] em,
                        input logic cf, input logic [12:0] ef);
        exp_t it;
        rst = r; en = e; kill = k; mode = md; cc = cnt; sub = sb; dsum = d; cr = c; sat = st;
        q.push_back('{tag, cm, em, cf, ef});
        #2;
        it = q.pop_front();
        if (it.cm) begin
            checks++;
            assert (om === it.em) else begin
                errors++;
                $error("FAIL %s (fold=0): observed %b expected %b", it.tag, om, it.em);
            end
        end
        if (it.cf) begin
            checks++;
            assert (of === it.ef) else begin
                errors++;
                $error("FAIL %s (fold=1): observed %b expected %b", it.tag, of, it.ef);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; en = 0; kill = 0; mode = 0; cc = 0; sub = 0; dsum = 0; cr = 0; sat = 0;
        @(negedge clk);
        step("reset",      1,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        step("idle",       0,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        // single-cycle op
        step("c00_m16",    0,1,0, 2'd1,2'b00,2'b01, 1,0,0,
             1, x(2'd0,2'd1,2'd1,1,0,0,0,1,0,0), 1, x(2'd0,2'd1,2'd1,1,0,0,0,1,0,0));
        // code 11: LO, HI, ACC; input changes mid-op are ignored
        step("c11_lo",     0,1,0, 2'd3,2'b11,2'b10, 0,1,0,
             1, x(2'd0,2'd3,2'd2,0,1,1,0,0,0,0), 1, x(2'd0,2'd3,2'd2,0,1,1,0,0,0,0));
        step("c11_hi",     0,1,0, 2'd0,2'b11,2'b00, 0,0,0,
             1, x(2'd1,2'd3,2'd2,0,1,1,0,0,0,1), 1, x(2'd1,2'd3,2'd2,0,1,0,1,1,0,1));
        step("c11_acc",    0,1,0, 2'd0,2'b11,2'b00, 0,0,0,
             1, x(2'd2,2'd3,2'd2,0,1,0,1,1,0,1), 0, 13'd0);
        step("drain",      0,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 0, 13'd0);
        step("idle2",      0,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        // code 10: ACC path vs folded single cycle
        step("c10_lo",     0,1,0, 2'd0,2'b10,2'b00, 0,0,0,
             1, x(2'd0,2'd0,2'd0,0,0,1,0,0,0,0), 1, x(2'd0,2'd0,2'd0,0,0,0,1,1,0,0));
        step("c10_acc",    0,0,0, 2'd0,2'b00,2'b00, 0,0,0,
             1, x(2'd2,2'd0,2'd0,0,0,0,1,1,0,1), 1, 13'd0);
        // kill in MUL_HI also drops sat seen earlier
        step("kill_lo",    0,1,0, 2'd2,2'b11,2'b01, 0,0,1,
             1, x(2'd0,2'd2,2'd1,0,0,1,0,0,0,0), 1, x(2'd0,2'd2,2'd1,0,0,1,0,0,0,0));
        step("kill_hi",    0,1,1, 2'd2,2'b11,2'b01, 0,0,0,
             1, x(2'd1,2'd2,2'd1,0,0,0,0,0,0,1), 1, x(2'd1,2'd2,2'd1,0,0,0,0,0,0,1));
        step("kill_after", 0,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        step("post_kill",  0,1,0, 2'd1,2'b00,2'b00, 0,0,0,
             1, x(2'd0,2'd1,2'd0,0,0,0,0,1,0,0), 1, x(2'd0,2'd1,2'd0,0,0,0,0,1,0,0));
        // sticky saturation
        step("sat_lo",     0,1,0, 2'd3,2'b01,2'b00, 0,0,1,
             1, x(2'd0,2'd3,2'd0,0,0,1,0,0,0,0), 1, x(2'd0,2'd3,2'd0,0,0,1,0,0,0,0));
        step("sat_hi",     0,1,0, 2'd3,2'b01,2'b00, 0,0,0,
             1, x(2'd1,2'd3,2'd0,0,0,0,0,1,1,1), 1, x(2'd1,2'd3,2'd0,0,0,0,0,1,1,1));
        step("sat_next",   0,1,0, 2'd0,2'b00,2'b00, 0,0,0,
             1, x(2'd0,2'd0,2'd0,0,0,0,0,1,0,0), 1, x(2'd0,2'd0,2'd0,0,0,0,0,1,0,0));
        step("sat_valid",  0,1,0, 2'd2,2'b00,2'b00, 0,0,1,
             1, x(2'd0,2'd2,2'd0,0,0,0,0,1,1,0), 1, x(2'd0,2'd2,2'd0,0,0,0,0,1,1,0));
        // reset while in ACC, then reset together with a request
        step("rst_lo",     0,1,0, 2'd3,2'b11,2'b11, 1,1,0,
             1, x(2'd0,2'd3,2'd3,1,1,1,0,0,0,0), 1, x(2'd0,2'd3,2'd3,1,1,1,0,0,0,0));
        step("rst_hi",     0,1,0, 2'd3,2'b11,2'b11, 1,1,0,
             1, x(2'd1,2'd3,2'd3,1,1,1,0,0,0,1), 1, x(2'd1,2'd3,2'd3,1,1,0,1,1,0,1));
        step("rst_in_acc", 1,1,0, 2'd3,2'b11,2'b11, 1,1,0,
             1, x(2'd2,2'd3,2'd3,1,1,0,0,0,0,1), 1, x(2'd0,2'd3,2'd3,1,1,0,0,0,0,0));
        step("rst_with_en",1,1,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        step("rst_after",  0,0,0, 2'd0,2'b00,2'b00, 0,0,0, 1, 13'd0, 1, 13'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
